// File: rtl/linear_layer_srl_fifo.sv
`default_nettype none
// ============================================================================
// Module   : linear_layer_srl_fifo
// Purpose  : Shift-register FIFO with first-word fall-through read, registered
//            status flags, occupancy count and sticky overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module linear_layer_srl_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_count,
    output logic                  if_almost_full,
    output logic                  if_almost_empty,
    output logic                  if_ovf,
    output logic                  if_udf
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] c_one   = CW'(1);
    localparam logic [CW-1:0] c_zero  = CW'(0);
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);
    localparam logic [CW-1:0] c_af    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] c_ae    = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]         r_count;
    logic                  r_full_n;
    logic                  r_empty_n;
    logic                  r_almost_full;
    logic                  r_almost_empty;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [CW-1:0]         w_count_nxt;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    assign w_wr_acc = if_write & if_write_ce & r_full_n;
    assign w_rd_acc = if_read  & if_read_ce  & r_empty_n;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + c_one;
            2'b01:   w_count_nxt = r_count - c_one;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage is deliberately left out of reset; only the bookkeeping clears.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !reset) begin
            r_mem[0] <= if_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count        <= c_zero;
            r_full_n       <= 1'b1;
            r_empty_n      <= 1'b0;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_ovf          <= 1'b0;
            r_udf          <= 1'b0;
        end else begin
            r_count        <= w_count_nxt;
            r_full_n       <= (w_count_nxt != c_depth);
            r_empty_n      <= (w_count_nxt != c_zero);
            r_almost_full  <= (w_count_nxt >= c_af);
            r_almost_empty <= (w_count_nxt <= c_ae);
            if (if_write && if_write_ce && !r_full_n) begin
                r_ovf <= 1'b1;
            end
            if (if_read && if_read_ce && !r_empty_n) begin
                r_udf <= 1'b1;
            end
        end
    end

    generate
        if (DEPTH == 1) begin : g_single
            assign w_rd_addr = '0;
        end else begin : g_multi
            // Oldest entry sits at count-1; registered so dout is a pure mux.
            localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);
            logic [ADDR_WIDTH-1:0] r_rd_addr;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rd_addr <= '1;
                end else begin
                    r_rd_addr <= w_count_nxt[ADDR_WIDTH-1:0] - c_addr_one;
                end
            end
            assign w_rd_addr = r_rd_addr;
        end
    endgenerate

    assign if_dout         = r_mem[w_rd_addr];
    assign if_full_n       = r_full_n;
    assign if_empty_n      = r_empty_n;
    assign if_count        = r_count;
    assign if_almost_full  = r_almost_full;
    assign if_almost_empty = r_almost_empty;
    assign if_ovf          = r_ovf;
    assign if_udf          = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_linear_layer_srl_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_linear_layer_srl_fifo
// Purpose  : Scoreboard bench for linear_layer_srl_fifo against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_linear_layer_srl_fifo;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wce = 1'b0, wr = 1'b0, rce = 1'b0, rd = 1'b0;
    logic [DW-1:0] din = '0;
    logic          full_n, empty_n, almost_full, almost_empty, ovf, udf;
    logic [DW-1:0] dout;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    linear_layer_srl_fifo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk), .reset(reset),
        .if_write_ce(wce), .if_write(wr), .if_din(din), .if_full_n(full_n),
        .if_read_ce(rce), .if_read(rd), .if_dout(dout), .if_empty_n(empty_n),
        .if_count(count), .if_almost_full(almost_full),
        .if_almost_empty(almost_empty), .if_ovf(ovf), .if_udf(udf)
    );

    typedef struct {
        int           cnt;
        bit           ovf;
        bit           udf;
        logic [DW-1:0] head;
    } stat_t;

    stat_t         sq[$];
    logic [DW-1:0] rq[$];
    logic [DW-1:0] mq[$];
    bit            m_ovf, m_udf, m_valid;
    int            total = 0;
    int            bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle; expectations describe model state before the coming edge.
    task automatic cyc(input bit r, input bit w, input bit wc, input logic [DW-1:0] d,
                       input bit rr, input bit rc);
        stat_t s;
        bit    full, empty;
        @(negedge clk);
        reset = r; wr = w; wce = wc; din = d; rd = rr; rce = rc;
        if (m_valid) begin
            s.cnt  = mq.size();
            s.ovf  = m_ovf;
            s.udf  = m_udf;
            s.head = (mq.size() > 0) ? mq[0] : '0;
            sq.push_back(s);
        end
        if (r) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            full  = (mq.size() == DEPTH);
            empty = (mq.size() == 0);
            if (w && wc && full)  m_ovf = 1'b1;
            if (rr && rc && empty) m_udf = 1'b1;
            if (rr && rc && !empty) begin
                rq.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (w && wc && !full) mq.push_back(d);
        end
    endtask

    task automatic wr1(input logic [DW-1:0] d); cyc(0, 1, 1, d, 0, 1); endtask
    task automatic rd1();                       cyc(0, 0, 1, '0, 1, 1); endtask
    task automatic rw1(input logic [DW-1:0] d); cyc(0, 1, 1, d, 1, 1); endtask
    task automatic idle();                      cyc(0, 0, 1, '0, 0, 1); endtask

    // Monitor: state checks every cycle, data check on every accepted read.
    initial begin
        stat_t s;
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (sq.size() > 0) begin
                s = sq.pop_front();
                chk("count",        32'(count),        32'(s.cnt));
                chk("full_n",       32'(full_n),       32'(s.cnt != DEPTH));
                chk("empty_n",      32'(empty_n),      32'(s.cnt != 0));
                chk("almost_full",  32'(almost_full),  32'(s.cnt >= AF));
                chk("almost_empty", 32'(almost_empty), 32'(s.cnt <= AE));
                chk("ovf",          32'(ovf),          32'(s.ovf));
                chk("udf",          32'(udf),          32'(s.udf));
                if (s.cnt > 0) chk("head", 32'(dout), 32'(s.head));
            end
            if (!reset && rd && rce && empty_n) begin
                if (rq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_data: got %0h expected no read", dout);
                end else begin
                    e = rq.pop_front();
                    chk("rd_data", 32'(dout), 32'(e));
                end
            end
        end
    end

    initial begin
        cyc(1, 0, 0, '0, 0, 0);
        cyc(1, 1, 1, 8'hEE, 1, 1);
        // fill then drain in order
        wr1(8'h11); wr1(8'h22); wr1(8'h33); wr1(8'h44); idle();
        rd1(); rd1(); rd1(); rd1(); idle();
        // steady state read+write at count 2
        wr1(8'h01); wr1(8'h02);
        rw1(8'h55); rw1(8'h55); rw1(8'h55);
        rd1(); rd1(); idle();
        // full read+write: write dropped, ovf set
        wr1(8'hA1); wr1(8'hA2); wr1(8'hA3); wr1(8'hA4);
        rw1(8'h66); rd1(); rd1(); rd1(); idle();
        // empty read+write: read dropped, udf set
        rw1(8'h77); idle(); rd1(); idle();
        // reset mid-operation with a concurrent write
        wr1(8'hB1); wr1(8'hB2); wr1(8'hB3);
        cyc(1, 1, 1, 8'h99, 0, 0);
        wr1(8'h88); idle(); rd1(); idle();
        // disabled requests while empty and while full
        for (int i = 0; i < 5; i++) cyc(0, i[0], 0, 8'hC0, ~i[0], 0);
        wr1(8'hD1); wr1(8'hD2); wr1(8'hD3); wr1(8'hD4);
        for (int i = 0; i < 5; i++) cyc(0, ~i[0], 0, 8'hC1, i[0], 0);
        rd1(); rd1(); rd1(); rd1(); idle();
        // randomized traffic with occasional reset
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 99) < 55),
                ($urandom_range(0, 9) != 0), DW'($urandom),
                ($urandom_range(0, 99) < 50), ($urandom_range(0, 9) != 0));
        end
        idle(); idle();
        @(negedge clk);
        #5;
        chk("read_queue_drained", 32'(rq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/linear_layer_srl_fifo.md
LINEAR_LAYER_SRL_FIFO -- requirements
Module: linear_layer_srl_fifo

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 32, meaning the payload width in bits (DATA_WIDTH >= 1).
REQ-002 The block SHALL expose parameter ADDR_WIDTH, default 2, meaning the read-address width, with 2**ADDR_WIDTH >= DEPTH.
REQ-003 The block SHALL expose parameter DEPTH, default 4, meaning the entry count (DEPTH >= 1).
REQ-004 The block SHALL expose parameter AF_LEVEL, default DEPTH-1, meaning the almost-full threshold in entries (1..DEPTH).
REQ-005 The block SHALL expose parameter AE_LEVEL, default 1, meaning the almost-empty threshold in entries (0..DEPTH-1).
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-008 The block SHALL have port if_write_ce, input, 1 bit, the write-side clock enable.
REQ-009 The block SHALL have port if_write, input, 1 bit, the write request.
REQ-010 The block SHALL have port if_din, input, DATA_WIDTH bits, the write data.
REQ-011 The block SHALL have port if_full_n, output, 1 bit, high when at least one entry is free.
REQ-012 The block SHALL have port if_read_ce, input, 1 bit, the read-side clock enable.
REQ-013 The block SHALL have port if_read, input, 1 bit, the read request.
REQ-014 The block SHALL have port if_dout, output, DATA_WIDTH bits, the head-of-queue data.
REQ-015 The block SHALL have port if_empty_n, output, 1 bit, high when at least one entry is valid.
REQ-016 The block SHALL have port if_count, output, ADDR_WIDTH+1 bits, the current occupancy.
REQ-017 The block SHALL have port if_almost_full, output, 1 bit, high when if_count >= AF_LEVEL.
REQ-018 The block SHALL have port if_almost_empty, output, 1 bit, high when if_count <= AE_LEVEL.
REQ-019 The block SHALL have port if_ovf, output, 1 bit, a sticky flag set by a write attempted while full.
REQ-020 The block SHALL have port if_udf, output, 1 bit, a sticky flag set by a read attempted while empty.

Function
REQ-021 Storage SHALL be a DEPTH-entry shift register: on accepted write, entry[i+1] <= entry[i] for all i, and entry[0] <= if_din.
REQ-022 A write SHALL be accepted iff if_write & if_write_ce & if_full_n; a read SHALL be accepted iff if_read & if_read_ce & if_empty_n.
REQ-023 if_dout SHALL be combinational entry[rd_addr], with rd_addr = count-1 (first-word fall-through; no read latency).
REQ-024 When the FIFO is empty, if_dout SHALL be don't-care; the bench SHALL NOT check it.
REQ-025 Write only: count+1; read only: count-1; both or neither: count unchanged; rd_addr SHALL track count-1 in the same cycle.
REQ-026 When full, a simultaneous read and write SHALL accept the read only, because if_full_n is low; count then becomes DEPTH-1.
REQ-027 When empty, a simultaneous read and write SHALL accept the write only; count then becomes 1.
REQ-028 if_full_n, if_empty_n, if_almost_full and if_almost_empty SHALL be registered and SHALL match the next count value in the same edge that updates count.
REQ-029 Write-to-read latency SHALL be 1 cycle: data written at edge N SHALL be visible on if_dout, with if_empty_n high, after edge N.
REQ-030 if_ovf SHALL be set on if_write & if_write_ce & ~if_full_n, and if_udf on if_read & if_read_ce & ~if_empty_n; both SHALL stay set until reset.
REQ-031 Requests with their clock enable low SHALL have no effect on any state or flag.
REQ-032 With DEPTH=1, if_full_n and if_empty_n SHALL be complementary, and rd_addr SHALL be constant 0.

Reset
REQ-033 While reset=1 at a clock edge: count=0, if_empty_n=0, if_full_n=1, if_almost_empty=1, if_almost_full=0 (or 1 only if AF_LEVEL=0 is illegal), if_ovf=0, if_udf=0.
REQ-034 Reset SHALL override any concurrent read or write; storage contents SHALL NOT be reset.
REQ-035 Reset asserted mid-operation SHALL discard all entries; the first edge after deassertion SHALL accept a write normally.

Verification (DEPTH=4, DATA_WIDTH=8, AF_LEVEL=3, AE_LEVEL=1)
REQ-036 Write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1..4; if_almost_full rises after the 3rd write; if_full_n=0 after the 4th; if_dout=0x11 throughout.
REQ-037 From full, read 4 times -> if_dout sequence 0x11,0x22,0x33,0x44; if_empty_n=0 after the 4th read; if_almost_empty=1 from count 1.
REQ-038 At count 2, read and write 0x55 together for 3 cycles -> count stays 2; order preserved; 0x55 emerges after the prior entries.
REQ-039 Full plus read&write of 0x66 -> only the read is accepted (count 3), 0x66 is dropped, if_ovf=1; empty plus read&write of 0x77 -> count 1, if_dout=0x77, if_udf=1.
REQ-040 At count 3, assert reset for 1 cycle with if_write=1 -> count=0, if_empty_n=0, flags cleared; the next write of 0x88 yields if_dout=0x88.
REQ-041 Toggle if_write and if_read with both clock enables low for 5 cycles -> no state change and no sticky flags set.
